// File: rtl/mix_ts_byte_framer.sv
// Mixed-stream TS byte framer: buffers whole 50-word packets from the mixed-stream
// sender, strips the 3-word routing header into sideband registers and serialises
// the 188-byte TS payload MSB-first onto a ready/valid byte stream with sop/eop.
module mix_ts_byte_framer #(
    parameter int FIFO_AW   = 9,
    parameter int PKT_WORDS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ts_din,
    input  logic        ts_din_en,
    input  logic        byte_ready,
    output logic [7:0]  byte_dout,
    output logic        byte_dout_en,
    output logic        byte_sop,
    output logic        byte_eop,
    output logic [7:0]  hdr_sfp,
    output logic [31:0] hdr_ip,
    output logic [15:0] hdr_port,
    output logic [15:0] drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam int CW    = $clog2(PKT_WORDS + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(PKT_WORDS - 1);
    localparam logic [CW-1:0] PAY_WORDS = CW'(PKT_WORDS - 3);
    localparam logic [7:0]    EOP_CNT   = 8'((PKT_WORDS - 3) * 4 - 1);
    localparam logic [PW:0]   DEPTH_X   = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   PKT_X     = (PW + 1)'(PKT_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_LOAD, S_PAY} state_t;

    logic [31:0]   r_mem [0:DEPTH-1];
    logic [31:0]   r_rd_data;

    // write side state
    logic          r_din_en_d;
    logic [PW-1:0] r_wr_ptr, r_wr_cmt;
    logic [CW-1:0] r_wcnt;
    logic          r_dropping;
    logic [PW-1:0] r_pkt_cnt;
    logic [15:0]   r_drop_cnt;

    // read side state
    state_t        r_state;
    logic [PW-1:0] r_rd_ptr;
    logic          r_rd_vld;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_words_left;
    logic [31:0]   r_nxt;
    logic          r_nxt_vld;
    logic [31:0]   r_shreg;
    logic [7:0]    r_bcnt;
    logic          r_en, r_sop, r_eop;
    logic [7:0]    r_hdr_sfp;
    logic [31:0]   r_hdr_ip;
    logic [15:0]   r_hdr_port;

    // write side decode; free space uses only committed words and the live read pointer
    logic          w_first, w_fall, w_room, w_wr_en, w_last, w_runt, w_drop;
    logic [PW-1:0] w_level;
    logic [PW:0]   w_free;
    logic [CW-1:0] w_cnt_cur;

    assign w_first   = ts_din_en && !r_din_en_d;
    assign w_fall    = !ts_din_en && r_din_en_d;
    assign w_level   = r_wr_cmt - r_rd_ptr;
    assign w_free    = DEPTH_X - {1'b0, w_level};
    assign w_room    = (w_free >= PKT_X);
    assign w_cnt_cur = w_first ? '0 : r_wcnt;
    assign w_wr_en   = ts_din_en && (w_first ? w_room : (!r_dropping && (r_wcnt <= LAST_WORD)));
    assign w_last    = w_wr_en && (w_cnt_cur == LAST_WORD);
    assign w_runt    = w_fall && !r_dropping && (r_wcnt <= LAST_WORD);
    assign w_drop    = (w_first && !w_room) || w_runt;

    // read side decode; one-word skid (r_nxt) keeps bytes flowing while ready stays high
    logic          w_acc, w_eop_acc, w_need, w_src_vld, w_take, w_rd_en, w_pkt_dec;
    logic [31:0]   w_src;
    logic [7:0]    w_bcnt_nxt;

    assign w_acc      = r_en && byte_ready;
    assign w_eop_acc  = w_acc && r_eop;
    assign w_need     = (r_state == S_PAY) &&
                        (!r_en || (w_acc && (r_bcnt[1:0] == 2'd3) && !r_eop));
    assign w_src_vld  = r_nxt_vld || r_rd_vld;
    assign w_src      = r_nxt_vld ? r_nxt : r_rd_data;
    assign w_take     = w_need && w_src_vld;
    assign w_bcnt_nxt = r_en ? (r_bcnt + 8'd1) : r_bcnt;
    assign w_rd_en    = (r_state == S_HDR) || (r_state == S_LOAD) ||
                        ((r_state == S_PAY) && (r_words_left != '0) && !r_rd_vld && !r_nxt_vld);
    assign w_pkt_dec  = (r_state == S_PAY) && w_eop_acc;

    // word buffer: block RAM with registered read port
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= ts_din;
        if (w_rd_en)
            r_rd_data <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
    end

    // packet admission, commit, runt rewind and drop counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_din_en_d <= 1'b0;
            r_wr_ptr   <= '0;
            r_wr_cmt   <= '0;
            r_wcnt     <= '0;
            r_dropping <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_din_en_d <= ts_din_en;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_wcnt   <= w_cnt_cur + 1'b1;
            end
            if (w_last)
                r_wr_cmt <= r_wr_ptr + 1'b1;
            if (w_first && !w_room) begin
                r_dropping <= 1'b1;
                r_wcnt     <= '0;
            end
            if (w_fall) begin
                r_dropping <= 1'b0;
                r_wcnt     <= '0;
            end
            if (w_runt)
                r_wr_ptr <= r_wr_cmt;
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
            case ({w_last, w_pkt_dec})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    // read FSM: header strip, payload load and byte serialisation with skid prefetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= '0;
            r_rd_vld     <= 1'b0;
            r_idx        <= '0;
            r_words_left <= '0;
            r_nxt        <= '0;
            r_nxt_vld    <= 1'b0;
            r_shreg      <= '0;
            r_bcnt       <= '0;
            r_en         <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_hdr_sfp    <= '0;
            r_hdr_ip     <= '0;
            r_hdr_port   <= '0;
        end else begin
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rd_vld <= w_rd_en;
            case (r_state)
                S_IDLE: begin
                    r_nxt_vld <= 1'b0;
                    if (r_pkt_cnt != '0) begin
                        r_state <= S_HDR;
                        r_idx   <= '0;
                    end
                end
                S_HDR: begin
                    if (r_idx == 2'd1)
                        r_hdr_sfp <= r_rd_data[15:8];
                    if (r_idx == 2'd2) begin
                        r_hdr_ip <= r_rd_data;
                        r_state  <= S_LOAD;
                    end
                    r_idx <= r_idx + 2'd1;
                end
                S_LOAD: begin
                    r_hdr_port   <= r_rd_data[31:16];
                    r_words_left <= PAY_WORDS - 1'b1;
                    r_bcnt       <= '0;
                    r_en         <= 1'b0;
                    r_sop        <= 1'b0;
                    r_eop        <= 1'b0;
                    r_nxt_vld    <= 1'b0;
                    r_state      <= S_PAY;
                end
                default: begin
                    if (w_rd_en)
                        r_words_left <= r_words_left - 1'b1;
                    if (r_rd_vld && !(w_take && !r_nxt_vld)) begin
                        r_nxt     <= r_rd_data;
                        r_nxt_vld <= 1'b1;
                    end else if (w_take && r_nxt_vld) begin
                        r_nxt_vld <= 1'b0;
                    end
                    if (w_eop_acc) begin
                        r_en    <= 1'b0;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b0;
                        r_shreg <= '0;
                        r_state <= S_IDLE;
                    end else if (w_need) begin
                        r_bcnt <= w_bcnt_nxt;
                        if (w_src_vld) begin
                            r_shreg <= w_src;
                            r_en    <= 1'b1;
                            r_sop   <= (w_bcnt_nxt == 8'd0);
                            r_eop   <= (w_bcnt_nxt == EOP_CNT);
                        end else begin
                            r_en  <= 1'b0;
                            r_sop <= 1'b0;
                            r_eop <= 1'b0;
                        end
                    end else if (w_acc) begin
                        r_shreg <= {r_shreg[23:0], 8'h00};
                        r_bcnt  <= r_bcnt + 8'd1;
                        r_sop   <= 1'b0;
                        r_eop   <= ((r_bcnt + 8'd1) == EOP_CNT);
                    end
                end
            endcase
        end
    end

    assign byte_dout    = r_shreg[31:24];
    assign byte_dout_en = r_en;
    assign byte_sop     = r_sop;
    assign byte_eop     = r_eop;
    assign hdr_sfp      = r_hdr_sfp;
    assign hdr_ip       = r_hdr_ip;
    assign hdr_port     = r_hdr_port;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_mix_ts_byte_framer.sv
// Scoreboard bench for mix_ts_byte_framer: expected payload bytes and header sideband
// are queued when a packet is driven and compared on every accepted output byte.
module tb_mix_ts_byte_framer;
    localparam int PKT_WORDS = 50;
    localparam int PAY_BYTES = 188;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ts_din = '0;
    logic        ts_din_en = 1'b0;
    logic        byte_ready = 1'b0;
    logic [7:0]  byte_dout;
    logic        byte_dout_en, byte_sop, byte_eop;
    logic [7:0]  hdr_sfp;
    logic [31:0] hdr_ip;
    logic [15:0] hdr_port;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    mix_ts_byte_framer #(.FIFO_AW(9), .PKT_WORDS(PKT_WORDS)) dut (
        .clk(clk), .rst(rst), .ts_din(ts_din), .ts_din_en(ts_din_en),
        .byte_ready(byte_ready), .byte_dout(byte_dout), .byte_dout_en(byte_dout_en),
        .byte_sop(byte_sop), .byte_eop(byte_eop), .hdr_sfp(hdr_sfp), .hdr_ip(hdr_ip),
        .hdr_port(hdr_port), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [7:0]  b;
        logic        sop;
        logic        eop;
        logic [7:0]  sfp;
        logic [31:0] ip;
        logic [15:0] port;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   commit_cyc = 0;
    int   sop_cyc = 0;
    int   acc_total = 0;
    int   pkt_out = 0;
    int   exp_drop = 0;
    bit   rdy_toggle = 1'b0;
    logic rdy_level = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sfp_of(input int p);
        return 8'(3 + p);
    endfunction
    function automatic logic [31:0] ip_of(input int p);
        return 32'hC0A8_0001 + 32'(p);
    endfunction
    function automatic logic [15:0] port_of(input int p);
        return 16'h1F90 + 16'(p);
    endfunction
    function automatic logic [7:0] pay_byte(input int p, input int k);
        if (k == 0) return 8'h47;
        return 8'((k - 1) + p * 13);
    endfunction
    function automatic logic [31:0] pkt_word(input int p, input int i);
        int j;
        if (i == 0) return {16'h0000, sfp_of(p), 8'h00};
        if (i == 1) return ip_of(p);
        if (i == 2) return {port_of(p), 16'h0000};
        j = (i - 3) * 4;
        return {pay_byte(p, j), pay_byte(p, j + 1), pay_byte(p, j + 2), pay_byte(p, j + 3)};
    endfunction

    // advance one cycle and update byte_ready just after the edge
    task automatic tick;
        @(posedge clk);
        #1;
        if (rdy_toggle) byte_ready = ~byte_ready;
        else            byte_ready = rdy_level;
    endtask

    task automatic send_pkt(input int p, input int nwords, input bit expect_out);
        exp_t e;
        if (expect_out) begin
            for (int k = 0; k < PAY_BYTES; k++) begin
                e.b = pay_byte(p, k); e.sop = (k == 0); e.eop = (k == PAY_BYTES - 1);
                e.sfp = sfp_of(p); e.ip = ip_of(p); e.port = port_of(p);
                sb_q.push_back(e);
            end
        end
        for (int i = 0; i < nwords; i++) begin
            tick;
            ts_din_en = 1'b1;
            ts_din = (i < PKT_WORDS) ? pkt_word(p, i) : (32'hDEAD_0000 + 32'(i));
            if (i == PKT_WORDS - 1) commit_cyc = cyc + 1;
        end
        tick;
        ts_din_en = 1'b0;
        ts_din = '0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 6000) begin
            tick;
            n++;
        end
        chk({tag, "_left"}, 96'(sb_q.size()), 96'd0);
        repeat (4) tick;
    endtask

    // output monitor: one scoreboard pop per accepted byte, one line per packet
    always @(negedge clk) begin
        if (rst && byte_dout_en && byte_ready) begin
            chk("sb_nonempty", 96'(sb_q.size() != 0), 96'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("byte", 96'({byte_dout, byte_sop, byte_eop}), 96'({mon_e.b, mon_e.sop, mon_e.eop}));
                chk("hdr", 96'({hdr_sfp, hdr_ip, hdr_port}), 96'({mon_e.sfp, mon_e.ip, mon_e.port}));
            end
            acc_total = acc_total + 1;
            if (byte_sop) sop_cyc = cyc;
            if (byte_eop) begin
                pkt_out = pkt_out + 1;
                $display("pkt %0d out sfp=%02h ip=%08h port=%04h drop=%0d",
                         pkt_out, hdr_sfp, hdr_ip, hdr_port, drop_cnt);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst = 1'b0;
        rdy_level = 1'b1;
        repeat (3) tick;
        chk("reset_outputs", 96'({byte_dout, byte_dout_en, byte_sop, byte_eop, hdr_sfp, hdr_ip, hdr_port, drop_cnt}), 96'd0);
        rst = 1'b1;
        repeat (2) tick;

        // single packet, ready held high
        send_pkt(0, PKT_WORDS, 1'b1);
        drain("single");
        chk("sop_latency", 96'(sop_cyc - commit_cyc), 96'd6);
        chk("single_pkts", 96'(pkt_out), 96'd1);
        chk("single_drop", 96'(drop_cnt), 96'(exp_drop));

        // back-pressure: ready alternates every cycle
        rdy_toggle = 1'b1;
        send_pkt(1, PKT_WORDS, 1'b1);
        drain("bp");
        rdy_toggle = 1'b0;
        chk("bp_pkts", 96'(pkt_out), 96'd2);

        // overflow: 12 back-to-back packets while the MAC stalls
        rdy_level = 1'b0;
        for (int p = 2; p < 14; p++) send_pkt(p, PKT_WORDS, p < 12);
        exp_drop += 2;
        repeat (10) tick;
        chk("ovf_drop", 96'(drop_cnt), 96'(exp_drop));
        chk("ovf_held", 96'(pkt_out), 96'd2);
        rdy_level = 1'b1;
        drain("ovf");
        chk("ovf_pkts", 96'(pkt_out), 96'd12);

        // runt followed by a good packet
        send_pkt(14, 20, 1'b0);
        exp_drop += 1;
        send_pkt(15, PKT_WORDS, 1'b1);
        drain("runt");
        chk("runt_drop", 96'(drop_cnt), 96'(exp_drop));
        chk("runt_pkts", 96'(pkt_out), 96'd13);

        // overlong packet, then a good packet to expose any leaked extra words
        send_pkt(16, PKT_WORDS + 3, 1'b1);
        send_pkt(17, PKT_WORDS, 1'b1);
        drain("long");
        chk("long_drop", 96'(drop_cnt), 96'(exp_drop));
        chk("long_pkts", 96'(pkt_out), 96'd15);

        // reset while byte 100 of a packet is on the output
        base = acc_total;
        send_pkt(18, PKT_WORDS, 1'b1);
        n = 0;
        while (acc_total < base + 100 && n < 2000) begin
            tick;
            n++;
        end
        chk("rst_reached_byte100", 96'(acc_total - base), 96'd100);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", 96'({byte_dout, byte_dout_en, byte_sop, byte_eop, hdr_sfp, hdr_ip, hdr_port, drop_cnt}), 96'd0);
        sb_q.delete();
        exp_drop = 0;
        repeat (3) tick;
        rst = 1'b1;
        repeat (2) tick;
        send_pkt(19, PKT_WORDS, 1'b1);
        drain("after_rst");
        chk("after_rst_drop", 96'(drop_cnt), 96'(exp_drop));
        chk("after_rst_pkts", 96'(pkt_out), 96'd16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mix_ts_byte_framer.md
Name: mix_ts_byte_framer

Overview:
- Sits directly downstream of the mixed-stream sender and consumes its 32-bit ts_dout/ts_dout_en stream.
- Buffers whole packets and strips each 3-word routing header.
- Serialises the 188-byte TS payload MSB-first onto an 8-bit stream with sop/eop, gated by a ready handshake from the GbE/UDP MAC.
- Presents the header fields (sfp_num, ip, port) as sideband that is valid from sop through eop.

Parameters:
- FIFO_AW, 9, word-FIFO address width; depth = 2^FIFO_AW words (512 = 10 packets).
- PKT_WORDS, 50, words per input packet (3 header + 47 payload).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- ts_din  input  32  mixed stream word
- ts_din_en  input  1  word valid; high for exactly PKT_WORDS contiguous cycles per packet, with ≥1 low cycle between packets
- byte_ready  input  1  MAC accepts byte_dout this cycle
- byte_dout  output  8  payload byte
- byte_dout_en  output  1  byte valid
- byte_sop  output  1  first payload byte of packet
- byte_eop  output  1  last (188th) payload byte
- hdr_sfp  output  8  word0[15:8]
- hdr_ip  output  32  word1
- hdr_port  output  16  word2[31:16]
- drop_cnt  output  16  packets discarded, saturating

Behaviour:
- Reset (rst low, async): all outputs 0; FIFO pointers, committed pointer, packet count and FSM cleared. Reset mid-packet discards everything.
- Write side:
  - Shadow write pointer wr_ptr; committed pointer wr_cmt.
  - On the first word of a packet (en rising), free = depth − (wr_cmt − rd_ptr). If free < PKT_WORDS, the whole packet is dropped: no words written, drop_cnt+1.
  - Otherwise the words are written at wr_ptr.
  - When word PKT_WORDS is written, wr_cmt ← wr_ptr+1 and pkt_cnt+1.
  - Runt packet (en falls before word PKT_WORDS): wr_ptr ← wr_cmt (rewind) and drop_cnt+1.
  - Overlong packet: words beyond PKT_WORDS are ignored until en goes low. No extra drop is counted.
  - drop_cnt saturates at 0xFFFF.
- Read FSM:
  - IDLE: when pkt_cnt>0, go to HDR.
  - HDR: read 3 words on consecutive cycles (registered FIFO read, 1-cycle latency) and latch hdr_sfp/hdr_ip/hdr_port. Then LOAD.
  - LOAD: fetch payload word into a 32-bit shift register. Then PAY.
  - PAY: byte_dout_en=1, byte_dout = shreg[31:24].
    - A byte advances only when byte_ready=1; otherwise byte_dout/en/sop/eop are held.
    - After the 4th accepted byte of a word, the next word is already prefetched (one-word skid) so there are no bubbles while byte_ready stays high.
    - Byte counter 0..187: byte_sop at count 0, byte_eop at count 187.
    - On the accepted eop: pkt_cnt−1, then IDLE.
  - Header sideband changes only in HDR, so it is stable from sop through eop.
- Latency: packet committed at cycle T → byte_sop valid at T+6 at the earliest (1 pkt_cnt register, 3 HDR reads, 1 LOAD, 1 output register).
- Simultaneous events:
  - Commit and eop in the same cycle leave pkt_cnt unchanged (+1−1).
  - The free-space check uses rd_ptr of the current cycle.
  - Write and read never address the same uncommitted word.
- Pointers are FIFO_AW+1 bits and wrap naturally; full = MSB differs and the lower bits are equal.
- Throughput: input averages ≤1 word per 4 cycles sustained; bursts are absorbed by the FIFO.

Test Plan:
- Single packet: word0=0x0000_0300, ip=0xC0A8_0001, word2=0x1F90_0000, payload bytes 0x47,0x00,…; byte_ready=1 → hdr_sfp=0x03, hdr_ip=0xC0A80001, hdr_port=0x1F90; 188 contiguous bytes, first byte 0x47 with byte_sop, eop on the 188th; sop at commit+6.
- Back-pressure: toggle byte_ready 1/0 every cycle → each byte is held while ready=0; byte order and count (188) are intact; sop/eop appear exactly once.
- Overflow: 12 back-to-back packets with byte_ready=0 → 10 packets buffered, drop_cnt=2. Raise ready → 10 packets emerge in order with correct headers.
- Runt: en high for 20 words then low, followed by a good packet → drop_cnt=1; only the good packet is output; the FIFO level returns to its pre-runt value.
- Overlong: en high for 53 words → one packet output; the 3 extra words do not appear; drop_cnt unchanged.
- Reset mid-output: assert rst low during byte 100 → all outputs 0 immediately. After release, a new packet is output cleanly from sop.
